// File: rtl/glb_write_stream_pkg.sv
// glb_stream_pkg: shared types and helpers for the GLB write stream source.
//   state_e      : sequencer states
//   GLB_STREAM_DW: stream word width (last flag + 16-bit word)
//   GLB_WORD_W   : payload / size field width
//   clamp_size   : limit a requested block size to the buffer depth
package glb_stream_pkg;

    localparam int GLB_STREAM_DW = 17;
    localparam int GLB_WORD_W    = 16;

    typedef enum logic [2:0] {IDLE, HDR0, BODY0, HDR1, BODY1, FIN} state_e;

    function automatic logic [GLB_WORD_W-1:0] clamp_size(input logic [GLB_WORD_W-1:0] size,
                                                         input int unsigned depth);
        clamp_size = (32'(size) > depth) ? GLB_WORD_W'(depth) : size;
    endfunction

endpackage

// File: rtl/glb_write_stream_if.sv
// glb_write_stream_if: 17-bit valid/ready stream channel.
//   data  : stream word, bit 16 optional last flag
//   valid : source has a word on data
//   ready : sink accepts the word
//   master modport drives data/valid, slave modport drives ready.
interface glb_write_stream_if;
    import glb_stream_pkg::*;

    logic [GLB_STREAM_DW-1:0] data;
    logic                     valid;
    logic                     ready;

    modport master(output data, valid, input ready);
    modport slave(input data, valid, output ready);

endinterface

// File: rtl/glb_write_stream_out_reg.sv
// glb_stream_out_reg: single-entry valid/ready output register.
//   clk, rst_n  : clock, async active-low reset
//   clr_i       : drop the held word (abort / restart)
//   in_valid_i, in_ready_o, in_data_i    : upstream side
//   out_valid_o, out_ready_i, out_data_o : downstream side, driven from registers only
module glb_stream_out_reg #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         load;

    // Accept a new word when empty or when the held word leaves this cycle.
    assign in_ready_o = !valid_q || out_ready_i;
    assign load       = in_valid_i && in_ready_o && !clr_i;

    always_comb begin
        valid_d = clr_i ? 1'b0 : load ? 1'b1 : out_ready_i ? 1'b0 : valid_q;
        data_d  = load ? in_data_i : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/glb_write_stream.sv
// glb_write_stream: GLB-side source sending one or two length-prefixed blocks per flush.
//   clk, rst_n     : clock, async active-low reset
//   flush_i        : arms the sequencer; its falling edge starts transmission, high aborts
//   cfg_wr_en_i, cfg_blk_i, cfg_addr_i, cfg_wdata_i : block buffer write port
//   cfg_size_0_i, cfg_size_1_i : block word counts, sampled at start
//   strm           : stream master (data/valid out, ready in)
//   done_o         : all blocks accepted by the sink
// Optional: define GLB_WRITE_STREAM_LAST_EN to flag the last word of each block in data[16].
module glb_write_stream
    import glb_stream_pkg::*;
#(
    parameter int NUM_BLOCKS = 1,
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  cfg_wr_en_i,
    input  logic                  cfg_blk_i,
    input  logic [ADDR_W-1:0]     cfg_addr_i,
    input  logic [GLB_WORD_W-1:0] cfg_wdata_i,
    input  logic [GLB_WORD_W-1:0] cfg_size_0_i,
    input  logic [GLB_WORD_W-1:0] cfg_size_1_i,
    glb_write_stream_if.master    strm,
    output logic                  done_o
);

    state_e                   state_q, state_d, nxt;
    logic                     flush_q, done_q, done_d;
    logic [GLB_WORD_W-1:0]    sz0_q, sz0_d, sz1_q, sz1_d, idx_q, idx_d;
    logic                     start, in_hdr, blk1, in_valid, in_ready, hs, idx_last, wr_ok;
    logic                     out_valid;
    logic [GLB_WORD_W-1:0]    sz, rd0, rd1, word;
    logic [GLB_STREAM_DW-1:0] in_data, out_data;
    logic [GLB_WORD_W-1:0]    buf0_q [DEPTH];

    assign start    = flush_q && !flush_i;
    assign blk1     = state_q == HDR1 || state_q == BODY1;
    assign in_hdr   = state_q == HDR0 || state_q == HDR1;
    assign in_valid = (in_hdr || state_q == BODY0 || state_q == BODY1) && !flush_i;
    assign hs       = in_valid && in_ready;
    assign sz       = blk1 ? sz1_q : sz0_q;
    assign idx_last = idx_q == sz - 16'd1;
    assign nxt      = (!blk1 && NUM_BLOCKS == 2) ? HDR1 : FIN;
    // Buffers are only writable while nothing is being streamed from them.
    assign wr_ok    = cfg_wr_en_i && (state_q == IDLE || state_q == FIN) && !start;

    always_ff @(posedge clk) begin
        if (wr_ok && !cfg_blk_i) buf0_q[cfg_addr_i] <= cfg_wdata_i;
    end

    assign rd0 = buf0_q[idx_q[ADDR_W-1:0]];

    if (NUM_BLOCKS == 2) begin : g_buf1
        logic [GLB_WORD_W-1:0] buf1_q [DEPTH];
        always_ff @(posedge clk) begin
            if (wr_ok && cfg_blk_i) buf1_q[cfg_addr_i] <= cfg_wdata_i;
        end
        assign rd1 = buf1_q[idx_q[ADDR_W-1:0]];
    end else begin : g_nobuf1
        assign rd1 = '0;
    end

    assign word = in_hdr ? sz : blk1 ? rd1 : rd0;

`ifdef GLB_WRITE_STREAM_LAST_EN
    // A zero-size block ends at its header.
    assign in_data = {in_hdr ? (sz == '0) : idx_last, word};
`else
    assign in_data = {1'b0, word};
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sz0_d   = sz0_q;
        sz1_d   = sz1_q;
        if (flush_i) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (start) begin
            state_d = HDR0;
            idx_d   = '0;
            sz0_d   = clamp_size(cfg_size_0_i, DEPTH);
            sz1_d   = clamp_size(cfg_size_1_i, DEPTH);
        end else if (hs) begin
            if (in_hdr) begin
                state_d = (sz == '0) ? nxt : blk1 ? BODY1 : BODY0;
            end else begin
                idx_d   = idx_last ? '0 : idx_q + 16'd1;
                state_d = idx_last ? nxt : state_q;
            end
        end
        // done waits for the sink to take the final word, not just the sequencer.
        done_d = !flush_i && !start && (done_q || (state_q == FIN && (!out_valid || strm.ready)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
            done_q  <= 1'b0;
            sz0_q   <= '0;
            sz1_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_i;
            done_q  <= done_d;
            sz0_q   <= sz0_d;
            sz1_q   <= sz1_d;
            idx_q   <= idx_d;
        end
    end

    glb_stream_out_reg #(.W(GLB_STREAM_DW)) u_out (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (flush_i || start),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .out_valid_o(out_valid),
        .out_ready_i(strm.ready),
        .out_data_o (out_data)
    );

    assign strm.valid = out_valid;
    assign strm.data  = out_data;
    assign done_o     = done_q;

endmodule

// File: tb/tb_glb_write_stream.sv
// tb_glb_write_stream: directed bench for glb_write_stream (single- and dual-block instances).
module tb_glb_write_stream;

`ifdef GLB_WRITE_STREAM_LAST_EN
    localparam bit LE = 1'b1;
`else
    localparam bit LE = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, flush1 = 1'b0, flush2 = 1'b0;
    logic        cfg_wr_en = 1'b0, cfg_blk = 1'b0, ready = 1'b0;
    logic [9:0]  cfg_addr = '0;
    logic [15:0] cfg_wdata = '0, size0 = '0, size1 = '0;
    logic        done1, done2;
    int          n_chk = 0, n_fail = 0;
    logic [16:0] got[$], exp_q[$];

    always #5 clk = ~clk;

    glb_write_stream_if s1();
    glb_write_stream_if s2();
    assign s1.ready = ready;
    assign s2.ready = ready;

    glb_write_stream #(.NUM_BLOCKS(1), .DEPTH(1024)) u1 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush1), .cfg_wr_en_i(cfg_wr_en), .cfg_blk_i(cfg_blk),
        .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata), .cfg_size_0_i(size0), .cfg_size_1_i(size1),
        .strm(s1), .done_o(done1));

    glb_write_stream #(.NUM_BLOCKS(2), .DEPTH(16)) u2 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush2), .cfg_wr_en_i(cfg_wr_en), .cfg_blk_i(cfg_blk),
        .cfg_addr_i(cfg_addr[3:0]), .cfg_wdata_i(cfg_wdata), .cfg_size_0_i(size0), .cfg_size_1_i(size1),
        .strm(s2), .done_o(done2));

    typedef struct {
        bit          st;
        bit          rdy;
        bit          v;
        logic [16:0] d;
        bit          dn;
    } vec_t;
    vec_t vec[19];

    function automatic logic [16:0] mk(input bit last, input logic [15:0] w);
        return {LE & last, w};
    endfunction

    function automatic logic vld(input int d);
        return d == 1 ? s1.valid : s2.valid;
    endfunction

    function automatic logic [16:0] dat(input int d);
        return d == 1 ? s1.data : s2.data;
    endfunction

    function automatic logic dn(input int d);
        return d == 1 ? done1 : done2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // All stimulus tasks are entered and left at a falling edge.
    task automatic wr(input bit blk, input logic [9:0] a, input logic [15:0] v);
        cfg_wr_en = 1'b1; cfg_blk = blk; cfg_addr = a; cfg_wdata = v;
        @(negedge clk);
        cfg_wr_en = 1'b0;
    endtask

    task automatic pulse(input int d);
        if (d == 1) flush1 = 1'b1; else flush2 = 1'b1;
        @(negedge clk);
        flush1 = 1'b0; flush2 = 1'b0;
    endtask

    task automatic collect(input string name, input int d, input int max_cyc, input bit toggle, input int wr_at);
        got.delete();
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (dn(d)) break;
            ready     = toggle ? 1'($urandom) : 1'b1;
            cfg_wr_en = (c == wr_at);
            cfg_blk   = 1'b0;
            cfg_addr  = 10'd1000;
            cfg_wdata = 16'hFFFF;
            if (vld(d) && ready) got.push_back(dat(d));
        end
        cfg_wr_en = 1'b0;
        chk({name, " done"}, 32'(dn(d)), 32'd1);
        chk({name, " count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s word%0d", name, i), 32'(got[i]), 32'(exp_q[i]));
    endtask

    initial begin
        vec[0]  = '{1, 1, 0, 17'h0, 0};
        vec[1]  = '{0, 1, 1, mk(0, 16'h0003), 0};
        vec[2]  = '{0, 1, 1, mk(0, 16'h1111), 0};
        vec[3]  = '{0, 1, 1, mk(0, 16'h2222), 0};
        vec[4]  = '{0, 1, 1, mk(1, 16'h3333), 0};
        vec[5]  = '{0, 1, 0, 17'h0, 1};
        vec[6]  = '{0, 1, 0, 17'h0, 1};
        vec[7]  = '{1, 1, 0, 17'h0, 0};
        vec[8]  = '{0, 1, 1, mk(0, 16'h0003), 0};
        vec[9]  = '{0, 0, 1, mk(0, 16'h0003), 0};
        vec[10] = '{0, 0, 1, mk(0, 16'h0003), 0};
        vec[11] = '{0, 1, 1, mk(0, 16'h1111), 0};
        vec[12] = '{0, 0, 1, mk(0, 16'h1111), 0};
        vec[13] = '{0, 1, 1, mk(0, 16'h2222), 0};
        vec[14] = '{0, 0, 1, mk(0, 16'h2222), 0};
        vec[15] = '{0, 1, 1, mk(1, 16'h3333), 0};
        vec[16] = '{0, 0, 1, mk(1, 16'h3333), 0};
        vec[17] = '{0, 1, 0, 17'h0, 1};
        vec[18] = '{0, 0, 0, 17'h0, 1};

        repeat (2) @(negedge clk);
        chk("rst valid1", 32'(s1.valid), 0);
        chk("rst data1", 32'(s1.data), 0);
        chk("rst done1", 32'(done1), 0);
        chk("rst valid2", 32'(s2.valid), 0);
        chk("rst data2", 32'(s2.data), 0);
        chk("rst done2", 32'(done2), 0);
        rst_n = 1'b1;
        @(negedge clk);

        wr(0, 0, 16'h1111); wr(0, 1, 16'h2222); wr(0, 2, 16'h3333);
        size0 = 16'd3;
        for (int i = 0; i < 19; i++) begin
            if (vec[i].st) pulse(1);
            ready = vec[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d valid", i), 32'(s1.valid), 32'(vec[i].v));
            chk($sformatf("vec%0d done", i), 32'(done1), 32'(vec[i].dn));
            if (vec[i].v) chk($sformatf("vec%0d data", i), 32'(s1.data), 32'(vec[i].d));
        end

        wr(1, 0, 16'hAAAA); wr(1, 1, 16'hBBBB);
        size0 = 16'd0; size1 = 16'd2;
        exp_q = '{mk(1, 16'h0000), mk(0, 16'h0002), mk(0, 16'hAAAA), mk(1, 16'hBBBB)};
        pulse(2);
        collect("two_blk", 2, 200, 1, -1);

        size0 = 16'd3;
        exp_q = '{mk(0, 16'h0003), mk(0, 16'h1111), mk(0, 16'h2222), mk(1, 16'h3333)};
        pulse(1);
        collect("blk1_ignored", 1, 50, 0, -1);

        for (int i = 0; i < 5; i++) wr(0, 10'(i), 16'h0100 + 16'(i));
        size0 = 16'd5;
        pulse(1);
        ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort hdr", 32'(s1.data), 32'(mk(0, 16'h0005)));
        repeat (2) @(negedge clk);
        chk("abort word1", 32'(s1.data), 32'(mk(0, 16'h0101)));
        flush1 = 1'b1; ready = 1'b0;
        @(negedge clk);
        chk("abort valid", 32'(s1.valid), 0);
        chk("abort done", 32'(done1), 0);
        @(negedge clk);
        chk("abort valid hold", 32'(s1.valid), 0);
        chk("abort done hold", 32'(done1), 0);
        flush1 = 1'b0;
        exp_q = '{mk(0, 16'h0005), mk(0, 16'h0100), mk(0, 16'h0101), mk(0, 16'h0102),
                  mk(0, 16'h0103), mk(1, 16'h0104)};
        collect("restart", 1, 50, 0, -1);

        for (int i = 0; i < 1024; i++) wr(0, 10'(i), 16'(i) ^ 16'h5A5A);
        size0 = 16'h0800;
        exp_q.delete();
        exp_q.push_back(mk(0, 16'h0400));
        for (int i = 0; i < 1024; i++) exp_q.push_back(mk(i == 1023, 16'(i) ^ 16'h5A5A));
        pulse(1);
        collect("clamp", 1, 1200, 0, 10);

        size0 = 16'd5;
        pulse(1);
        ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset valid", 32'(s1.valid), 1);
        rst_n = 1'b0;
        #1;
        chk("async rst valid", 32'(s1.valid), 0);
        chk("async rst done", 32'(done1), 0);
        chk("async rst data", 32'(s1.data), 0);
        @(negedge clk);
        rst_n = 1'b1; ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("no resume valid", 32'(s1.valid), 0);
        chk("no resume done", 32'(done1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/glb_write_stream.md
Name: glb_write_stream

Overview:
- Synthesizable GLB-side stream source. It transmits one or two length-prefixed blocks over a 17-bit valid/ready channel.
- It is the transmitting end of the channel whose sink captures a size word followed by that many data words.
- Block contents and sizes are preloaded through a simple config write port.
- Transmission starts on the falling edge of flush. done is raised after the final block.

Parameters:
- NUM_BLOCKS, 1: number of blocks sent per flush. Legal values are 1 and 2.
- DEPTH, 1024: words per block buffer, a power of two.
- ADDR_W, $clog2(DEPTH): buffer address width.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  arms the sequencer; its falling edge starts transmission.
- cfg_wr_en  input  1  buffer write strobe.
- cfg_blk  input  1  target buffer for the write (0 or 1).
- cfg_addr  input  ADDR_W  buffer word address.
- cfg_wdata  input  16  buffer write data.
- cfg_size_0  input  16  word count of block 0, sampled at start.
- cfg_size_1  input  16  word count of block 1, sampled at start.
- data  output  17  stream word.
- valid  output  1  data is valid.
- ready  input  1  sink accepts data.
- done  output  1  all blocks sent.

Behaviour:
- Reset: async, active-low. data=0, valid=0, done=0, state=IDLE, counters=0. Buffer contents are not reset.
- Transfer: a word transfers on a rising edge where valid&&ready.
- Output stage: data and valid are driven only from registers. A new word loads when !valid || ready, so full throughput is one word per cycle with no bubbles. Once valid is high, data must not change until the handshake.
- flush_q is flush registered. The start event is flush_q && !flush.
- The start event clears done and valid. It also latches sz0/sz1 as min(cfg_size, DEPTH).
- IDLE: waits for the start event, then goes to HDR0.
- Flush abort: flush high in any state returns to IDLE, drops valid next cycle and clears counters.
- HDR0: presents {1'b0, sz0}. On handshake it goes to BODY0, or directly to the next phase if sz0==0.
- BODY0: presents {1'b0, buf0[idx]} for idx = 0..sz0-1. After the last handshake it goes to HDR1 if NUM_BLOCKS==2, else FIN.
- HDR1 / BODY1: identical to HDR0 / BODY0, using sz1 and buf1.
- FIN: done=1 on the cycle after the final handshake. Holds until the next start event, a flush assertion or reset.
- Word order: the header always precedes the body. No gap is required between blocks.
- Width: data[16] is 0 in the base build. data[15:0] is the size or the payload.
- Size clamp: a size field above DEPTH is clamped to DEPTH, and the clamped value is what goes in the header.
- Config writes: accepted only in IDLE or FIN and ignored otherwise. cfg_blk=1 is ignored when NUM_BLOCKS==1.
- Config during start: a write on the start cycle is ignored. Sizes are sampled on the start cycle only.
- Backpressure: ready low for any number of cycles holds data and valid stable. ready is allowed to be high while valid is low.
- Reset mid-transfer: outputs go to their reset values immediately. There is no resume; a new flush pulse is required.

Optional Feature:
- Macro: GLB_WRITE_STREAM_LAST_EN.
- Defined: data[16]=1 on the last word of each block. That is the final body word, or the header when size==0. data[16]=0 on all other words.
- Undefined: data[16] is tied to 0. No extra logic.

Decomposition:
- Package glb_stream_pkg:
  - state enum {IDLE, HDR0, BODY0, HDR1, BODY1, FIN}.
  - constants GLB_STREAM_DW=17 and GLB_WORD_W=16.
  - function clamp_size.
- Sub-module glb_stream_out_reg: a single-entry valid/ready output register with in_valid/in_ready/out_valid/out_ready. The top instantiates it once. The sequencer advances idx on in_valid&&in_ready.

Test Plan:
- buf0={0x1111,0x2222,0x3333}, sz0=3, flush pulse, ready=1 → data 0x00003,0x01111,0x02222,0x03333 on 4 consecutive cycles; done=1 the next cycle.
- Same setup with ready toggled 1,0,0,1,0,1… → identical sequence; data is stable while valid&&!ready; no word is duplicated or dropped.
- NUM_BLOCKS=2, sz0=0, sz1=2, buf1={0xAAAA,0xBBBB} → data 0x00000,0x00002,0x0AAAA,0x0BBBB; then done.
- sz0=5, flush reasserted after 2 handshakes → valid=0 the next cycle, done stays 0. A new flush pulse restarts from header 0x00005.
- sz0=0x0800 with DEPTH=1024 → header 0x00400 and exactly 1024 body words. A cfg write during BODY0 leaves the buffer unchanged.
- GLB_WRITE_STREAM_LAST_EN defined, sz0=2 → 0x00002, 0x0xxxx, 0x1xxxx. With sz0=0 the header is 0x10000. rst_n low mid-block → valid=0 and done=0 immediately.
